dmem_responder: RTL

- Memory-side responder for the multicycle core's data-memory port.
- Accepts one load/store request at a time over a valid/ready handshake and performs RISC-V sub-word access on an internal 64-bit-wide synchronous array.
  - Loads: byte lane extraction plus sign/zero extension.
  - Sub-doubleword stores: read-modify-write.
- Returns a response over a second valid/ready handshake, with an error flag for misaligned or out-of-range accesses.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_lane.sv | 67 ++++++
 rtl/dmem_responder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - funct3 encodings for RISC-V loads/stores
//   - responder FSM state type
//   - default array depth
package dmem_pkg;

  localparam int unsigned DMEM_DEPTH = 256;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: combinational byte-lane logic for one 64-bit memory word.
// Ports:
//   funct3     in   access size/sign
//   offset     in   byte offset within the word (addr[2:0])
//   word       in   current word contents
//   wdata      in   store data, right-aligned
//   load_data  out  extracted field, sign/zero extended to 64 bits
//   store_word out  word with the addressed bytes replaced by wdata
//   misaligned out  offset not a multiple of the access size
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  offset,
  input  logic [63:0] word,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] store_word,
  output logic        misaligned
);

  logic [5:0]  shamt;
  logic [63:0] field;
  logic [7:0]  bmask;
  logic [7:0]  bmask_sh;
  logic [63:0] bitmask;

  always_comb begin
    shamt = {offset, 3'b000};
    field = word >> shamt;

    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{56{field[7]}},  field[7:0]};
      F3_H:    load_data = {{48{field[15]}}, field[15:0]};
      F3_W:    load_data = {{32{field[31]}}, field[31:0]};
      F3_D:    load_data = field;
      F3_BU:   load_data = {56'd0, field[7:0]};
      F3_HU:   load_data = {48'd0, field[15:0]};
      F3_WU:   load_data = {32'd0, field[31:0]};
      default: load_data = '0;
    endcase

    // funct3[1:0] is the log2 size for both signed and unsigned variants
    case (funct3[1:0])
      2'd0:    bmask = 8'h01;
      2'd1:    bmask = 8'h03;
      2'd2:    bmask = 8'h0F;
      default: bmask = 8'hFF;
    endcase
    bmask_sh = bmask << offset;

    bitmask = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      bitmask[b*8 +: 8] = {8{bmask_sh[b]}};
    end
    store_word = (word & ~bitmask) | ((wdata << shamt) & bitmask);

    case (funct3[1:0])
      2'd1:    misaligned = offset[0];
      2'd2:    misaligned = |offset[1:0];
      2'd3:    misaligned = |offset;
      default: misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's data-memory port.
// One request at a time; sub-word loads with extension, sub-doubleword
// stores by read-modify-write on a 64-bit synchronous array.
// Ports:
//   clock, reset            rising-edge clock, async active-low reset
//   req_valid/req_ready     request handshake
//   req_we, req_funct3      store flag, RISC-V size/sign
//   req_addr, req_wdata     byte address, right-aligned store data
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata, rsp_err      load result (0 for stores/errors), error flag
// Optional (DMEM_STATS_EN): stat_loads, stat_stores, stat_errs saturating
// counters of completed responses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH,
  parameter int unsigned AW    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_errs
`endif
);

  dmem_state_t state, state_nxt;

  logic          we_q;
  logic [2:0]    f3_q;
  logic [2:0]    off_q;
  logic [63:0]   wdata_q;
  logic [AW-1:0] idx_q;
  logic [63:0]   rd_word;
  logic [63:0]   mem [DEPTH];

  logic [2:0]    lane_f3;
  logic [2:0]    lane_off;
  logic [63:0]   load_data;
  logic [63:0]   store_word;
  logic          misaligned;
  logic          illegal;
  logic          out_of_range;
  logic          req_err;
  logic          accept;
  logic          handshake;

  // Alignment is checked on the live request in IDLE; afterwards the lane
  // block works on the captured request.
  assign lane_f3  = (state == IDLE) ? req_funct3    : f3_q;
  assign lane_off = (state == IDLE) ? req_addr[2:0] : off_q;

  dmem_lane u_lane (
    .funct3     (lane_f3),
    .offset     (lane_off),
    .word       (rd_word),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word),
    .misaligned (misaligned)
  );

  assign illegal      = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
  assign out_of_range = (req_addr[63:3] >= 61'(DEPTH));
  assign req_err      = illegal | misaligned | out_of_range;
  assign accept       = (state == IDLE) && req_valid;
  assign handshake    = (state == RESP) && rsp_ready;

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_err ? RESP : RD;
      end
      RD:   state_nxt = we_q ? WR : RESP;
      WR:   state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      we_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      wdata_q   <= '0;
      idx_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q      <= req_we;
        f3_q      <= req_funct3;
        off_q     <= req_addr[2:0];
        wdata_q   <= req_wdata;
        idx_q     <= req_addr[AW+2:3];
        rsp_rdata <= '0;
        rsp_err   <= req_err;
      end else if (state == RD && !we_q) begin
        rsp_rdata <= load_data;
      end else if (handshake) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

  // rd_word doubles as the merge buffer: it holds the read word in RD and
  // the merged store word in WR.
  always_ff @(posedge clock) begin
    if (accept) rd_word <= mem[req_addr[AW+2:3]];
    else if (state == RD && we_q) rd_word <= store_word;
    if (state == WR) mem[idx_q] <= rd_word;
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errs   <= '0;
    end else if (handshake) begin
      if (rsp_err) begin
        if (stat_errs != '1) stat_errs <= stat_errs + 32'd1;
      end else if (we_q) begin
        if (stat_stores != '1) stat_stores <= stat_stores + 32'd1;
      end else begin
        if (stat_loads != '1) stat_loads <= stat_loads + 32'd1;
      end
    end
  end
`endif

endmodule
